// File: rtl/match_controller_if.sv
// Bus between the match controller and the scoreboard datapath.
// The free_hit status line exists only when FREE_HIT_EN is defined.
interface match_controller_if;
    logic       start;
    logic       delivery;
    logic [3:0] outcome;
    logic       batting_team;
    logic [7:0] runs;
    logic [3:0] wickets;
    logic [6:0] balls;
    logic [4:0] over_num;
    logic [2:0] ball_in_over;
    logic [8:0] target;
    logic [2:0] state;
    logic       inning_over;
    logic       game_over;
    logic [1:0] winner;
    logic       ball_accept;
`ifdef FREE_HIT_EN
    logic       free_hit;
`endif

    modport master (
        output start, delivery, outcome,
`ifdef FREE_HIT_EN
        input  free_hit,
`endif
        input  batting_team, runs, wickets, balls, over_num, ball_in_over,
        input  target, state, inning_over, game_over, winner, ball_accept
    );

    modport slave (
        input  start, delivery, outcome,
`ifdef FREE_HIT_EN
        output free_hit,
`endif
        output batting_team, runs, wickets, balls, over_num, ball_in_over,
        output target, state, inning_over, game_over, winner, ball_accept
    );
endinterface

// File: rtl/match_controller.sv
// Two-innings limited-overs match sequencer: per-team counters, innings/chase decisions, winner.
// Optional free-hit rule after a no-ball is built in when FREE_HIT_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   INN1  | team 1 batting
//   BRK   | inning break, down-counter running
//   INN2  | team 2 batting, chasing target
//   DONE  | match finished, winner latched
module match_controller #(
    parameter int MAX_BALLS    = 120,
    parameter int MAX_WICKETS  = 10,
    parameter int BREAK_CYCLES = 16
) (
    input  logic               clk_fpga,
    input  logic               reset,
    match_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INN1 = 3'd1,
        BRK  = 3'd2,
        INN2 = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int BW = (BREAK_CYCLES > 1) ? $clog2(BREAK_CYCLES) : 1;

    state_t          state_q;
    logic [7:0]      runs1, runs2;
    logic [3:0]      wkts1, wkts2;
    logic [6:0]      balls1, balls2;
    logic [8:0]      target_q;
    logic [1:0]      winner_q;
    logic            batting_q;
    logic            accept_q;
    logic [BW-1:0]   break_cnt;

    logic [2:0]      run_add;
    logic            legal, wkt, fh_active;
    logic            apply, start_go, chase, all_out, end_inn, break_done, show2;
    logic [7:0]      cur_runs, nxt_runs;
    logic [8:0]      run_sum;
    logic [3:0]      cur_wkts, nxt_wkts;
    logic [6:0]      cur_balls, nxt_balls, disp_balls;

    always_comb begin
        run_add = 3'd0;
        legal   = 1'b1;
        wkt     = 1'b0;
        case (bus.outcome)
            4'd0, 4'd1, 4'd2:        run_add = 3'd0;
            4'd3, 4'd4, 4'd5, 4'd6:  run_add = 3'd1;
            4'd7, 4'd8, 4'd9:        run_add = 3'd2;
            4'd10:                   run_add = 3'd3;
            4'd11:                   run_add = 3'd4;
            4'd12:                   run_add = 3'd6;
            4'd13, 4'd14: begin
                run_add = 3'd1;
                legal   = 1'b0;
            end
            default:                 wkt = ~fh_active;
        endcase
    end

    // Post-update values of the batting team; end of innings is judged on these.
    always_comb begin
        apply      = bus.delivery && (state_q == INN1 || state_q == INN2);
        start_go   = bus.start && (state_q == IDLE || state_q == DONE);
        cur_runs   = (state_q == INN2) ? runs2  : runs1;
        cur_wkts   = (state_q == INN2) ? wkts2  : wkts1;
        cur_balls  = (state_q == INN2) ? balls2 : balls1;
        run_sum    = {1'b0, cur_runs} + {6'b0, run_add};
        nxt_runs   = run_sum[8] ? 8'hFF : run_sum[7:0];
        nxt_wkts   = cur_wkts + {3'b0, wkt};
        nxt_balls  = cur_balls + {6'b0, legal};
        chase      = (state_q == INN2) && ({1'b0, nxt_runs} >= target_q);
        all_out    = (nxt_wkts == 4'(MAX_WICKETS)) || (nxt_balls == 7'(MAX_BALLS));
        end_inn    = apply && (all_out || chase);
        break_done = (state_q == BRK) && (break_cnt == '0);
    end

    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            runs1     <= '0;
            runs2     <= '0;
            wkts1     <= '0;
            wkts2     <= '0;
            balls1    <= '0;
            balls2    <= '0;
            target_q  <= '0;
            winner_q  <= '0;
            batting_q <= 1'b0;
            accept_q  <= 1'b0;
            break_cnt <= '0;
        end else begin
            accept_q <= apply;
            case (state_q)
                IDLE, DONE: begin
                    if (start_go) begin
                        state_q   <= INN1;
                        runs1     <= '0;
                        runs2     <= '0;
                        wkts1     <= '0;
                        wkts2     <= '0;
                        balls1    <= '0;
                        balls2    <= '0;
                        target_q  <= '0;
                        winner_q  <= '0;
                        batting_q <= 1'b0;
                    end
                end
                INN1: begin
                    if (apply) begin
                        runs1  <= nxt_runs;
                        wkts1  <= nxt_wkts;
                        balls1 <= nxt_balls;
                        if (end_inn) begin
                            state_q   <= BRK;
                            target_q  <= {1'b0, nxt_runs} + 9'd1;
                            break_cnt <= BW'(BREAK_CYCLES - 1);
                        end
                    end
                end
                BRK: begin
                    if (break_done) begin
                        state_q   <= INN2;
                        batting_q <= 1'b1;
                    end else begin
                        break_cnt <= break_cnt - 1'b1;
                    end
                end
                INN2: begin
                    if (apply) begin
                        runs2  <= nxt_runs;
                        wkts2  <= nxt_wkts;
                        balls2 <= nxt_balls;
                        if (end_inn) begin
                            state_q  <= DONE;
                            winner_q <= chase ? 2'b10 : (nxt_runs == runs1) ? 2'b11 : 2'b01;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FREE_HIT_EN
    logic free_hit_q;

    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset)
            free_hit_q <= 1'b0;
        else if (start_go || break_done || end_inn)
            free_hit_q <= 1'b0;
        else if (apply)
            free_hit_q <= (bus.outcome == 4'd14) || ((bus.outcome == 4'd13) && free_hit_q);
    end

    assign fh_active    = free_hit_q;
    assign bus.free_hit = free_hit_q;
`else
    assign fh_active = 1'b0;
`endif

    // Break shows team 1's final card; DONE keeps team 2's card on display.
    assign show2            = (state_q == INN2) || (state_q == DONE);
    assign disp_balls       = show2 ? balls2 : balls1;
    assign bus.runs         = show2 ? runs2 : runs1;
    assign bus.wickets      = show2 ? wkts2 : wkts1;
    assign bus.balls        = disp_balls;
    assign bus.over_num     = 5'(disp_balls / 7'd6);
    assign bus.ball_in_over = 3'(disp_balls % 7'd6);
    assign bus.batting_team = batting_q;
    assign bus.target       = target_q;
    assign bus.state        = state_q;
    assign bus.inning_over  = (state_q == BRK) || (state_q == DONE);
    assign bus.game_over    = (state_q == DONE);
    assign bus.winner       = winner_q;
    assign bus.ball_accept  = accept_q;
endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: vector table for innings 1, scoreboard queue of per-ball
// expectations, and hand sequences for break timing, chase, tie, saturation and reset.
module tb_match_controller;
    logic clk_fpga = 1'b0;
    logic reset;

    always #5 clk_fpga = ~clk_fpga;

    match_controller_if bus ();

    match_controller dut (
        .clk_fpga (clk_fpga),
        .reset    (reset),
        .bus      (bus)
    );

    typedef struct {
        int runs;
        int wk;
        int balls;
        int ov;
        int bio;
    } exp_t;

    typedef struct {
        logic [3:0] code;
        exp_t       e;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t tab[20];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_accept = 0;

    int   m_state, m_runs, m_wk, m_balls, m_target, m_runs1, m_winner;
    logic m_fh;
    int   run_tab[16] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 3, 4, 6, 1, 1, 0};

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    always @(negedge clk_fpga) begin
        if (bus.ball_accept === 1'b1) begin
            n_accept++;
            if (sb_q.size() == 0) begin
                check("unexpected_accept", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_runs",  int'(bus.runs),         mon_e.runs);
                check("sb_wkts",  int'(bus.wickets),      mon_e.wk);
                check("sb_balls", int'(bus.balls),        mon_e.balls);
                check("sb_over",  int'(bus.over_num),     mon_e.ov);
                check("sb_bio",   int'(bus.ball_in_over), mon_e.bio);
            end
        end
    end

    task automatic model_clear();
        m_runs = 0; m_wk = 0; m_balls = 0; m_fh = 1'b0;
    endtask

    task automatic predict(input logic [3:0] code, output exp_t e);
        logic fh;
        fh = 1'b0;
`ifdef FREE_HIT_EN
        fh = m_fh;
`endif
        m_runs = m_runs + run_tab[code];
        if (m_runs > 255) m_runs = 255;
        if (code != 4'd13 && code != 4'd14) m_balls++;
        if (code == 4'd15 && !fh) m_wk++;
        m_fh = (code == 4'd14) || (code == 4'd13 && m_fh);
        if (m_state == 1 && (m_wk == 10 || m_balls == 120)) begin
            m_state  = 2;
            m_target = m_runs + 1;
            m_runs1  = m_runs;
            m_fh     = 1'b0;
        end else if (m_state == 3 && (m_runs >= m_target || m_wk == 10 || m_balls == 120)) begin
            m_state  = 4;
            m_fh     = 1'b0;
            m_winner = (m_runs >= m_target) ? 2 : (m_runs == m_runs1) ? 3 : 1;
        end
        e = '{m_runs, m_wk, m_balls, m_balls / 6, m_balls % 6};
    endtask

    task automatic pulse_delivery(input logic [3:0] code);
        @(negedge clk_fpga);
        bus.outcome  = code;
        bus.delivery = 1'b1;
        @(negedge clk_fpga);
        bus.delivery = 1'b0;
    endtask

    task automatic ball(input logic [3:0] code);
        exp_t e;
        predict(code, e);
        sb_q.push_back(e);
        pulse_delivery(code);
        check("accept_pulse", int'(bus.ball_accept), 1);
        check("state_after_ball", int'(bus.state), m_state);
    endtask

    task automatic table_ball(input vec_t v);
        exp_t dummy;
        predict(v.code, dummy);
        sb_q.push_back(v.e);
        pulse_delivery(v.code);
        check("tab_accept", int'(bus.ball_accept), 1);
    endtask

    task automatic ignored_ball(input logic [3:0] code, input string where);
        int r0, b0, w0;
        r0 = int'(bus.runs);
        b0 = int'(bus.balls);
        w0 = int'(bus.wickets);
        pulse_delivery(code);
        check({where, "_accept"}, int'(bus.ball_accept), 0);
        check({where, "_runs"},   int'(bus.runs),        r0);
        check({where, "_balls"},  int'(bus.balls),       b0);
        check({where, "_wkts"},   int'(bus.wickets),     w0);
    endtask

    task automatic start_match();
        @(negedge clk_fpga);
        bus.start = 1'b1;
        @(negedge clk_fpga);
        bus.start = 1'b0;
        m_state = 1; m_target = 0; m_winner = 0; m_runs1 = 0;
        model_clear();
        check("start_state",   int'(bus.state),        1);
        check("start_runs",    int'(bus.runs),         0);
        check("start_balls",   int'(bus.balls),        0);
        check("start_target",  int'(bus.target),       0);
        check("start_winner",  int'(bus.winner),       0);
        check("start_batting", int'(bus.batting_team), 0);
        check("start_gameovr", int'(bus.game_over),    0);
    endtask

    task automatic wait_inn2(input int budget);
        int n;
        n = 0;
        while (bus.state !== 3'd3 && n < budget) begin
            @(negedge clk_fpga);
            n++;
        end
        check("break_to_inn2", int'(bus.state), 3);
        check("inn2_batting",  int'(bus.batting_team), 1);
        m_state = 3;
        model_clear();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tab = '{
            '{4'd3,  '{1,  0, 1,  0, 1}}, '{4'd3,  '{2,  0, 2,  0, 2}},
            '{4'd3,  '{3,  0, 3,  0, 3}}, '{4'd3,  '{4,  0, 4,  0, 4}},
            '{4'd3,  '{5,  0, 5,  0, 5}}, '{4'd3,  '{6,  0, 6,  1, 0}},
            '{4'd13, '{7,  0, 6,  1, 0}}, '{4'd13, '{8,  0, 6,  1, 0}},
            '{4'd13, '{9,  0, 6,  1, 0}}, '{4'd12, '{15, 0, 7,  1, 1}},
            '{4'd0,  '{15, 0, 8,  1, 2}}, '{4'd2,  '{15, 0, 9,  1, 3}},
            '{4'd7,  '{17, 0, 10, 1, 4}}, '{4'd9,  '{19, 0, 11, 1, 5}},
            '{4'd10, '{22, 0, 12, 2, 0}}, '{4'd11, '{26, 0, 13, 2, 1}},
            '{4'd14, '{27, 0, 13, 2, 1}}, '{4'd6,  '{28, 0, 14, 2, 2}},
            '{4'd15, '{28, 1, 15, 2, 3}}, '{4'd8,  '{30, 1, 16, 2, 4}}
        };
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.delivery = 1'b0;
        bus.outcome  = 4'd0;
        m_state = 0; m_target = 0; m_winner = 0; m_runs1 = 0;
        model_clear();

        repeat (3) @(negedge clk_fpga);
        check("rst_state",   int'(bus.state),        0);
        check("rst_runs",    int'(bus.runs),         0);
        check("rst_balls",   int'(bus.balls),        0);
        check("rst_target",  int'(bus.target),       0);
        check("rst_winner",  int'(bus.winner),       0);
        check("rst_batting", int'(bus.batting_team), 0);
        check("rst_inn_ovr", int'(bus.inning_over),  0);
        check("rst_accept",  int'(bus.ball_accept),  0);
        reset = 1'b0;

        // start with a simultaneous delivery: the ball must be ignored
        @(negedge clk_fpga);
        bus.start = 1'b1; bus.delivery = 1'b1; bus.outcome = 4'd12;
        @(negedge clk_fpga);
        bus.start = 1'b0; bus.delivery = 1'b0;
        check("start_same_state",  int'(bus.state),       1);
        check("start_same_runs",   int'(bus.runs),        0);
        check("start_same_accept", int'(bus.ball_accept), 0);
        m_state = 1;

        for (int i = 0; i < 20; i++) table_ball(tab[i]);
        @(negedge clk_fpga);
        check("tab_accept_count", n_accept, 20);
        check("tab_state", int'(bus.state), 1);

        repeat (9) ball(4'd15);
        check("inn1_target",  int'(bus.target),       31);
        check("inn1_innovr",  int'(bus.inning_over),  1);
        check("break_batting", int'(bus.batting_team), 0);
        check("break_runs",   int'(bus.runs),         30);

        for (int i = 1; i <= 15; i++) begin
            @(negedge clk_fpga);
            if (i == 3) begin bus.delivery = 1'b1; bus.outcome = 4'd12; end
            if (i == 4) bus.delivery = 1'b0;
            if (i == 6) bus.start = 1'b1;
            if (i == 7) bus.start = 1'b0;
            check("break_hold",   int'(bus.state),       2);
            check("break_accept", int'(bus.ball_accept), 0);
        end
        @(negedge clk_fpga);
        check("break_exit",      int'(bus.state),        3);
        check("break_exit_bat",  int'(bus.batting_team), 1);
        check("inn2_runs0",      int'(bus.runs),         0);
        check("inn2_innovr",     int'(bus.inning_over),  0);
        m_state = 3;
        model_clear();

        ball(4'd13);
        @(negedge clk_fpga); bus.start = 1'b1;
        @(negedge clk_fpga); bus.start = 1'b0;
        check("inn2_start_ign", int'(bus.state), 3);
        check("inn2_start_runs", int'(bus.runs), 1);
        repeat (8) ball(4'd11);
        check("chase_runs",   int'(bus.runs),      33);
        check("chase_winner", int'(bus.winner),    2);
        check("chase_gameov", int'(bus.game_over), 1);
        check("chase_target", int'(bus.target),    31);
        ignored_ball(4'd12, "done_ign");
        check("done_winner_kept", int'(bus.winner), 2);

        // tie on the last legal ball
        start_match();
        repeat (5) ball(4'd7);
        repeat (10) ball(4'd15);
        check("tie_target", int'(bus.target), 11);
        wait_inn2(40);
        repeat (10) ball(4'd3);
        repeat (109) ball(4'd0);
        check("tie_pre_state", int'(bus.state),        3);
        check("tie_pre_over",  int'(bus.over_num),     19);
        check("tie_pre_bio",   int'(bus.ball_in_over), 5);
        ball(4'd0);
        check("tie_winner", int'(bus.winner),       3);
        check("tie_balls",  int'(bus.balls),        120);
        check("tie_over",   int'(bus.over_num),     20);
        check("tie_gameov", int'(bus.game_over),    1);

        // team 1 defends
        start_match();
        ball(4'd12);
        repeat (10) ball(4'd15);
        check("def_target", int'(bus.target), 7);
        wait_inn2(40);
        ball(4'd3);
        repeat (10) ball(4'd15);
        check("def_winner", int'(bus.winner), 1);

        // run saturation and 9-bit target
        start_match();
        repeat (43) ball(4'd12);
        check("sat_runs", int'(bus.runs), 255);
        repeat (10) ball(4'd15);
        check("sat_target", int'(bus.target), 256);
        wait_inn2(40);
        repeat (43) ball(4'd12);
        repeat (10) ball(4'd15);
        check("sat_winner", int'(bus.winner), m_winner);
        check("sat_winner_tie", int'(bus.winner), 3);

        // asynchronous reset mid-innings 2
        start_match();
        repeat (10) ball(4'd15);
        wait_inn2(40);
        ball(4'd0);
        @(negedge clk_fpga);
        #2 reset = 1'b1;
        #1;
        check("arst_state",   int'(bus.state),        0);
        check("arst_runs",    int'(bus.runs),         0);
        check("arst_balls",   int'(bus.balls),        0);
        check("arst_wkts",    int'(bus.wickets),      0);
        check("arst_over",    int'(bus.over_num),     0);
        check("arst_target",  int'(bus.target),       0);
        check("arst_winner",  int'(bus.winner),       0);
        check("arst_batting", int'(bus.batting_team), 0);
        check("arst_innovr",  int'(bus.inning_over),  0);
        @(negedge clk_fpga);
        reset = 1'b0;
        m_state = 0;

        // no-ball followed by a wicket code
        start_match();
        ball(4'd14);
`ifdef FREE_HIT_EN
        check("fh_armed", int'(bus.free_hit), 1);
`endif
        ball(4'd13);
`ifdef FREE_HIT_EN
        check("fh_wide_keeps", int'(bus.free_hit), 1);
`endif
        ball(4'd15);
`ifdef FREE_HIT_EN
        check("fh_cleared", int'(bus.free_hit), 0);
        check("fh_wicket",  int'(bus.wickets),  0);
`else
        check("fh_wicket",  int'(bus.wickets),  1);
`endif
        check("fh_balls", int'(bus.balls), 1);
        ball(4'd15);

        @(negedge clk_fpga);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
